// File: rtl/bert_drive_pkg.sv
// Shared types and constants for the BERT serial drive.
// clog2 is usable in parameter expressions.
package bert_drive_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int CPB_MIN = 2;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sym_fifo.sv
// Symbol FIFO with clock enable and a show-ahead read port.
// A push into a full FIFO is accepted only alongside a pop.
module sym_fifo
    import bert_drive_pkg::*;
#(
    parameter int  W     = 4,
    parameter int  DEPTH = 16,
    localparam int AW    = clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ce,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full     = level_q == LW'(DEPTH);
        empty    = level_q == '0;
        pop_ok   = pop && !empty;
        push_ok  = push && (!full || pop_ok);
        wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q + LW'(push_ok) - LW'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (ce) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ce && push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/bert_serial_drive.sv
// Buffers bursty symbols and replays them as an evenly spaced
// serial data/clock pair for an external BERT.
module bert_serial_drive
    import bert_drive_pkg::*;
#(
    parameter int  SYM_BITS    = 4,
    parameter int  FIFO_DEPTH  = 16,
    parameter int  CPB_WIDTH   = 16,
    parameter int  START_LEVEL = 8,
    localparam int LW          = clog2(FIFO_DEPTH) + 1,
    localparam int BW          = clog2(SYM_BITS + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 valid_in,
    input  logic [SYM_BITS-1:0]  data_in,
    input  logic [CPB_WIDTH-1:0] clocks_per_bit,
    input  logic                 msb_first,
    input  logic                 clear_status,
    output logic                 data_out,
    output logic                 clk_out,
    output logic [LW-1:0]        fifo_level,
    output logic                 overflow,
    output logic                 underrun
);

    state_e               state_q, state_d;
    logic [SYM_BITS-1:0]  sym_q, sym_d, shifted;
    logic                 msb_q, msb_d;
    logic [CPB_WIDTH-1:0] cpb_q, cpb_d, cpb_in;
    logic [CPB_WIDTH-1:0] cnt_q, cnt_d;
    logic [BW-1:0]        bits_q, bits_d;
    logic                 dout_q, dout_d;
    logic                 clko_q, clko_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 pop, load, unf_set, ovf_set;
    logic [SYM_BITS-1:0]  rdata;
    logic                 full, empty;
    logic [LW-1:0]        level;

    sym_fifo #(
        .W     (SYM_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .ce    (ce),
        .push  (valid_in),
        .wdata (data_in),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        cpb_in  = (clocks_per_bit < CPB_WIDTH'(CPB_MIN))
                ? CPB_WIDTH'(CPB_MIN) : clocks_per_bit;
        shifted = msb_q ? (sym_q << 1) : (sym_q >> 1);
        pop     = 1'b0;
        load    = 1'b0;
        unf_set = 1'b0;
        state_d = state_q;
        sym_d   = sym_q;
        msb_d   = msb_q;
        cpb_d   = cpb_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        dout_d  = dout_q;
        clko_d  = clko_q;
        unique case (state_q)
            IDLE: begin
                dout_d = 1'b0;
                clko_d = 1'b0;
                if (level >= LW'(START_LEVEL)) begin
                    pop  = 1'b1;
                    load = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    clko_d = 1'b0;
                    if (bits_q != '0) begin
                        sym_d  = shifted;
                        dout_d = msb_q ? shifted[SYM_BITS-1] : shifted[0];
                        bits_d = bits_q - BW'(1);
                        cnt_d  = cpb_q;
                    end else if (!empty) begin
                        pop  = 1'b1;
                        load = 1'b1;
                    end else begin
                        unf_set = 1'b1;
                        dout_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CPB_WIDTH'(1);
                    if (cnt_q == (cpb_q >> 1)) begin
                        clko_d = 1'b1;
                    end
                end
            end
        endcase
        // A load restarts the bit timing so back-to-back symbols share phase.
        if (load) begin
            state_d = RUN;
            sym_d   = rdata;
            msb_d   = msb_first;
            cpb_d   = cpb_in;
            cnt_d   = cpb_in;
            bits_d  = BW'(SYM_BITS - 1);
            dout_d  = msb_first ? rdata[SYM_BITS-1] : rdata[0];
            clko_d  = 1'b0;
        end
        ovf_set = valid_in && full && !pop;
        ovf_d   = (ovf_q && !clear_status) || ovf_set;
        unf_d   = (unf_q && !clear_status) || unf_set;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sym_q   <= '0;
            msb_q   <= 1'b0;
            cpb_q   <= '0;
            cnt_q   <= '0;
            bits_q  <= '0;
            dout_q  <= 1'b0;
            clko_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            sym_q   <= sym_d;
            msb_q   <= msb_d;
            cpb_q   <= cpb_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            dout_q  <= dout_d;
            clko_q  <= clko_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign data_out   = dout_q;
    assign clk_out    = clko_q;
    assign fifo_level = level;
    assign overflow   = ovf_q;
    assign underrun   = unf_q;

endmodule

// File: tb/tb_bert_serial_drive.sv
// Bench: two drives (start level 1 and 8) share stimulus and are
// checked each cycle against a bit-timeline model plus literal points.
module tb_bert_serial_drive;

    localparam int SB    = 4;
    localparam int DEPTH = 16;

    logic        clk, reset, ce, valid_in, msb_first, clear_status;
    logic [3:0]  data_in;
    logic [15:0] cpb;
    logic        a_dout, a_clk, a_ovf, a_unf;
    logic        b_dout, b_clk, b_ovf, b_unf;
    logic [4:0]  a_lvl, b_lvl;

    int nerr = 0;
    int nchk = 0;
    bit chk_en = 0;

    bert_serial_drive #(.START_LEVEL(1)) u_a (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(valid_in),
        .data_in(data_in), .clocks_per_bit(cpb), .msb_first(msb_first),
        .clear_status(clear_status), .data_out(a_dout), .clk_out(a_clk),
        .fifo_level(a_lvl), .overflow(a_ovf), .underrun(a_unf)
    );

    bert_serial_drive #(.START_LEVEL(8)) u_b (
        .clk(clk), .reset(reset), .ce(ce), .valid_in(valid_in),
        .data_in(data_in), .clocks_per_bit(cpb), .msb_first(msb_first),
        .clear_status(clear_status), .data_out(b_dout), .clk_out(b_clk),
        .fifo_level(b_lvl), .overflow(b_ovf), .underrun(b_unf)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Model: a symbol queue plus (symbol, bit index, phase within bit).
    logic [3:0] m_mem [2][DEPTH];
    int         m_head [2];
    int         m_cnt [2];
    bit         m_run [2];
    logic [3:0] m_sym [2];
    bit         m_msb [2];
    int         m_cpb [2];
    int         m_bit [2];
    int         m_ph [2];
    bit         m_ovf [2];
    bit         m_unf [2];
    bit         s_load, s_ovf, s_unf;

    function automatic int start_of(input int k);
        return (k == 0) ? 1 : 8;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_head[k] = 0; m_cnt[k] = 0; m_run[k] = 0;
                m_bit[k] = 0; m_ph[k] = 0;
                m_ovf[k] = 0; m_unf[k] = 0;
            end else if (ce) begin
                s_load = 0; s_unf = 0;
                if (!m_run[k]) begin
                    if (m_cnt[k] >= start_of(k)) s_load = 1;
                end else if (m_ph[k] < m_cpb[k]) begin
                    m_ph[k]++;
                end else if (m_bit[k] < SB - 1) begin
                    m_bit[k]++;
                    m_ph[k] = 0;
                end else if (m_cnt[k] > 0) begin
                    s_load = 1;
                end else begin
                    s_unf = 1;
                    m_run[k] = 0;
                end
                s_ovf = valid_in && (m_cnt[k] == DEPTH) && !s_load;
                if (s_load) begin
                    m_sym[k]  = m_mem[k][m_head[k]];
                    m_head[k] = (m_head[k] + 1) % DEPTH;
                    m_cnt[k]--;
                    m_run[k] = 1;
                    m_msb[k] = msb_first;
                    m_cpb[k] = (int'(cpb) < 2) ? 2 : int'(cpb);
                    m_bit[k] = 0;
                    m_ph[k]  = 0;
                end
                if (valid_in && !s_ovf) begin
                    m_mem[k][(m_head[k] + m_cnt[k]) % DEPTH] = data_in;
                    m_cnt[k]++;
                end
                m_ovf[k] = (m_ovf[k] && !clear_status) || s_ovf;
                m_unf[k] = (m_unf[k] && !clear_status) || s_unf;
            end
        end
    end

    function automatic int exp_dout(input int k);
        if (!m_run[k]) return 0;
        return m_msb[k] ? int'(m_sym[k][SB-1-m_bit[k]])
                        : int'(m_sym[k][m_bit[k]]);
    endfunction

    // Clock is high for the last cpb/2 phases of each bit.
    function automatic int exp_clk(input int k);
        if (!m_run[k]) return 0;
        return (m_ph[k] >= m_cpb[k] - m_cpb[k] / 2 + 1) ? 1 : 0;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_data_out", a_dout, exp_dout(0));
            check("a_clk_out", a_clk, exp_clk(0));
            check("a_fifo_level", a_lvl, m_cnt[0]);
            check("a_overflow", a_ovf, m_ovf[0]);
            check("a_underrun", a_unf, m_unf[0]);
            check("b_data_out", b_dout, exp_dout(1));
            check("b_clk_out", b_clk, exp_clk(1));
            check("b_fifo_level", b_lvl, m_cnt[1]);
            check("b_overflow", b_ovf, m_ovf[1]);
            check("b_underrun", b_unf, m_unf[1]);
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset = 1; valid_in = 0; clear_status = 0; ce = 1;
        @(negedge clk);
        reset = 0;
    endtask

    task automatic wait_to(inout int p, input int t);
        while (p < t) begin
            @(negedge clk);
            p++;
        end
    endtask

    task automatic write1(input logic [3:0] d, output int p);
        @(negedge clk);
        valid_in = 1; data_in = d;
        @(negedge clk);
        valid_in = 0;
        p = 1;
    endtask

    int p;
    int seq_l [4] = '{1, 1, 0, 1};
    int seq_m [4] = '{1, 0, 1, 1};

    initial begin
        reset = 1; ce = 1; valid_in = 0; data_in = 0;
        cpb = 9; msb_first = 0; clear_status = 0;
        do_reset();
        chk_en = 1;
        check("rst_a_dout", a_dout, 0);
        check("rst_a_clk", a_clk, 0);
        check("rst_a_lvl", a_lvl, 0);
        check("rst_b_ovf", b_ovf, 0);
        check("rst_b_unf", b_unf, 0);

        // LSB-first single symbol, 10-cycle bits
        write1(4'b1011, p);
        for (int b = 0; b < 4; b++) begin
            wait_to(p, 2 + 10 * b + 3);
            check("lsb_bit", a_dout, seq_l[b]);
            wait_to(p, 2 + 10 * b + 5);
            check("clk_low", a_clk, 0);
            wait_to(p, 2 + 10 * b + 6);
            check("clk_rise", a_clk, 1);
        end
        wait_to(p, 43);
        check("a_underrun_end", a_unf, 1);
        check("b_not_started", b_clk, 0);
        check("b_level_one", b_lvl, 1);

        // MSB-first
        do_reset();
        msb_first = 1;
        write1(4'b1011, p);
        for (int b = 0; b < 4; b++) begin
            wait_to(p, 2 + 10 * b + 3);
            check("msb_bit", a_dout, seq_m[b]);
        end
        wait_to(p, 45);
        msb_first = 0;

        // Pre-fill to 8 then 32 contiguous bit periods
        do_reset();
        cpb = 3;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            valid_in = 1; data_in = 4'(2 * i + 1);
        end
        @(negedge clk);
        valid_in = 0;
        repeat (20) @(negedge clk);
        check("b_prefill_lvl", b_lvl, 7);
        check("b_prefill_clk", b_clk, 0);
        write1(4'hF, p);
        check("b_start_lvl", b_lvl, 8);
        check("b_start_dout0", b_dout, 0);
        wait_to(p, 2);
        check("b_first_bit", b_dout, 1);
        wait_to(p, 2 + 127);
        check("b_no_gap_unf", b_unf, 0);
        check("b_last_clk", b_clk, 1);
        wait_to(p, 2 + 128);
        check("b_end_unf", b_unf, 1);
        check("b_end_dout", b_dout, 0);
        repeat (60) @(negedge clk);

        // Overflow with 20 back-to-back writes
        do_reset();
        cpb = 9;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            valid_in = 1; data_in = 4'(i);
        end
        @(negedge clk);
        valid_in = 0;
        check("b_full_lvl", b_lvl, 16);
        check("b_ovf_set", b_ovf, 1);
        check("a_full_lvl", a_lvl, 16);
        check("a_ovf_set", a_ovf, 1);
        clear_status = 1;
        @(negedge clk);
        clear_status = 0;
        check("b_ovf_clr", b_ovf, 0);
        check("a_ovf_clr", a_ovf, 0);
        repeat (760) @(negedge clk);
        check("b_drained", b_lvl, 0);
        check("b_drain_unf", b_unf, 1);

        // Steady stream: 4 symbols per 48 cycles at 12 cycles/symbol
        do_reset();
        cpb = 2;
        for (int k = 0; k < 6; k++) begin
            for (int j = 0; j < 4; j++) begin
                @(negedge clk);
                if (k > 0 && j == 0) begin
                    check("steady_b_unf", b_unf, 0);
                    check("steady_a_unf", a_unf, 0);
                    check("steady_b_bound", 32'(b_lvl <= 8), 1);
                end
                valid_in = 1; data_in = 4'(3 * k + j + 5);
            end
            @(negedge clk);
            valid_in = 0;
            repeat (43) @(negedge clk);
        end
        repeat (150) @(negedge clk);

        // Reset mid-symbol
        do_reset();
        cpb = 9;
        @(negedge clk);
        valid_in = 1; data_in = 4'b0110;
        @(negedge clk);
        data_in = 4'b1111;
        @(negedge clk);
        valid_in = 0;
        repeat (12) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        check("mid_rst_dout", a_dout, 0);
        check("mid_rst_clk", a_clk, 0);
        check("mid_rst_lvl", a_lvl, 0);
        check("mid_rst_blvl", b_lvl, 0);

        // ce low for 5 cycles stretches bit 0 by 5 cycles
        write1(4'b0001, p);
        wait_to(p, 4);
        ce = 0;
        wait_to(p, 9);
        ce = 1;
        wait_to(p, 12);
        check("ce_clk_low", a_clk, 0);
        wait_to(p, 13);
        check("ce_clk_rise", a_clk, 1);
        wait_to(p, 16);
        check("ce_bit0_held", a_dout, 1);
        wait_to(p, 17);
        check("ce_bit1", a_dout, 0);
        wait_to(p, 50);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not end, errors=%0d", nerr);
        $fatal(1);
    end

endmodule
